// File: rtl/frame_scheduler_pkg.sv
// Shared types and widths for the frame scheduler: FSM encoding, plot-port field widths,
// counter widths and default timing parameters.
package frame_scheduler_pkg;

  localparam int unsigned X_W             = 8;
  localparam int unsigned Y_W             = 7;
  localparam int unsigned C_W             = 3;
  localparam int unsigned TICK_W          = 28;
  localparam int unsigned WD_W            = 16;
  localparam int unsigned K_W             = 2;
  localparam int unsigned FC_W            = 16;
  localparam int unsigned DEF_TICK_CYCLES = 3000000;
  localparam int unsigned DEF_WD_CYCLES   = 65535;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_TICK  = 3'd1,
    ST_TICK       = 3'd2,
    ST_PASS_START = 3'd3,
    ST_PASS_RUN   = 3'd4
  } state_e;

endpackage

// File: rtl/frame_scheduler_tick_timer.sv
// Game-tick period timer: down counter with reload, expiry strobe, and the pending/overrun
// bookkeeping for ticks that expire while a frame is still rendering.
module frame_scheduler_tick_timer
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEF_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  logic in_wait,
  input  logic take,
  output logic expire_c,
  output logic pending,
  output logic overrun
);

  localparam logic [TICK_W-1:0] RELOAD = TICK_W'(TICK_CYCLES - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    expire_c  = en && (cnt_q == '0);
    if (load || expire_c) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = cnt_q - TICK_W'(1);
    end
    if (take) begin
      pending_d = 1'b0;
    end
    // Expiry while a frame is busy is remembered once; further expiries are dropped.
    if (expire_c && !in_wait) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: issues the game tick, then runs each render pass in turn with exclusive
// ownership of the VGA plot port, guarded by a per-pass watchdog.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned N_PASS      = 3,
  parameter int unsigned TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int unsigned WD_CYCLES   = DEF_WD_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  game_tick,
  output logic [N_PASS-1:0]     pass_start,
  input  logic [N_PASS-1:0]     pass_done,
  output logic [N_PASS-1:0]     grant,
  input  logic [X_W*N_PASS-1:0] req_x,
  input  logic [Y_W*N_PASS-1:0] req_y,
  input  logic [C_W*N_PASS-1:0] req_colour,
  input  logic [N_PASS-1:0]     req_plot,
  output logic [X_W-1:0]        vga_x,
  output logic [Y_W-1:0]        vga_y,
  output logic [C_W-1:0]        vga_colour,
  output logic                  vga_plot,
  output logic                  frame_done,
  output logic [FC_W-1:0]       frame_count,
  output logic                  overrun,
  output logic                  timeout_err
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(N_PASS - 1);

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              game_tick_q, game_tick_d;
  logic [N_PASS-1:0] pass_start_q, pass_start_d;
  logic [N_PASS-1:0] grant_q, grant_d;
  logic [X_W-1:0]    vga_x_q, vga_x_d;
  logic [Y_W-1:0]    vga_y_q, vga_y_d;
  logic [C_W-1:0]    vga_colour_q, vga_colour_d;
  logic              vga_plot_q, vga_plot_d;
  logic              frame_done_q, frame_done_d;
  logic [FC_W-1:0]   frame_count_q, frame_count_d;
  logic              timeout_q, timeout_d;

  logic tm_load, tm_take, tm_expire_c, tm_pending, tm_overrun;
  logic granted, sel_done, wd_hit;

  frame_scheduler_tick_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q != ST_IDLE),
    .load    (tm_load),
    .in_wait (state_q == ST_WAIT_TICK),
    .take    (tm_take),
    .expire_c(tm_expire_c),
    .pending (tm_pending),
    .overrun (tm_overrun)
  );

  // Current owner's done bit and registered plot mux; x/y/colour hold when nobody owns the port.
  always_comb begin
    granted      = (state_q == ST_PASS_START) || (state_q == ST_PASS_RUN);
    sel_done     = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    for (int i = 0; i < N_PASS; i++) begin
      if (k_q == K_W'(i)) begin
        sel_done = pass_done[i];
        if (granted) begin
          vga_x_d      = req_x[i*X_W +: X_W];
          vga_y_d      = req_y[i*Y_W +: Y_W];
          vga_colour_d = req_colour[i*C_W +: C_W];
          vga_plot_d   = req_plot[i];
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    wd_d          = wd_q;
    timeout_d     = timeout_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    tm_load       = 1'b0;
    tm_take       = 1'b0;
    wd_hit        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_WAIT_TICK;
          tm_load = 1'b1;
        end
      end
      ST_WAIT_TICK: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (tm_expire_c || tm_pending) begin
          state_d = ST_TICK;
          tm_take = 1'b1;
        end
      end
      ST_TICK: begin
        k_d     = '0;
        wd_d    = '0;
        state_d = ST_PASS_START;
      end
      ST_PASS_START: begin
        wd_d    = wd_q + WD_W'(1);
        state_d = ST_PASS_RUN;
      end
      ST_PASS_RUN: begin
        wd_d   = wd_q + WD_W'(1);
        wd_hit = (wd_q == WD_LAST);
        if (sel_done || wd_hit) begin
          wd_d = '0;
          if (wd_hit) begin
            timeout_d = 1'b1;
          end
          if (k_q == K_LAST) begin
            state_d       = ST_WAIT_TICK;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + FC_W'(1);
          end else begin
            k_d     = k_q + K_W'(1);
            state_d = ST_PASS_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes and grant are decoded from the next state so they line up with it.
    game_tick_d  = (state_d == ST_TICK);
    pass_start_d = '0;
    grant_d      = '0;
    for (int i = 0; i < N_PASS; i++) begin
      pass_start_d[i] = (state_d == ST_PASS_START) && (k_d == K_W'(i));
      grant_d[i]      = ((state_d == ST_PASS_START) || (state_d == ST_PASS_RUN)) &&
                        (k_d == K_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      wd_q          <= '0;
      game_tick_q   <= 1'b0;
      pass_start_q  <= '0;
      grant_q       <= '0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wd_q          <= wd_d;
      game_tick_q   <= game_tick_d;
      pass_start_q  <= pass_start_d;
      grant_q       <= grant_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      timeout_q     <= timeout_d;
    end
  end

  assign game_tick   = game_tick_q;
  assign pass_start  = pass_start_q;
  assign grant       = grant_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign overrun     = tm_overrun;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler (TICK_CYCLES=20, WD_CYCLES=16, N_PASS=3) with a pass
// responder model and a scoreboard queue for the plot mux.
module tb_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        game_tick, vga_plot, frame_done, overrun, timeout_err;
  logic [2:0]  pass_start, pass_done, grant, req_plot, vga_colour;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int dly[3];
  int tick_cnt = 0;
  int fd_cnt = 0;
  int g1_cnt = 0;
  int starts_obs[$];
  logic [18:0] exp_q[$];
  int exp_starts[$];

  frame_scheduler #(
    .N_PASS(3),
    .TICK_CYCLES(20),
    .WD_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .game_tick(game_tick),
    .pass_start(pass_start), .pass_done(pass_done), .grant(grant),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_plot(req_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .frame_done(frame_done), .frame_count(frame_count),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Pass responder (answers done dly[k] cycles after pass_start[k]; 0 = never) and event monitor.
  initial begin
    int rem;
    int idx;
    bit active;
    rem = 0; idx = 0; active = 1'b0;
    pass_done = '0;
    forever begin
      @(negedge clk);
      pass_done = '0;
      if (game_tick) tick_cnt++;
      if (frame_done) fd_cnt++;
      if (grant == 3'b010) g1_cnt++;
      if (reset) begin
        active = 1'b0;
      end else if (pass_start != '0) begin
        for (int i = 0; i < 3; i++) if (pass_start[i]) idx = i;
        starts_obs.push_back(idx);
        rem = dly[idx];
        active = (rem != 0);
      end else if (active) begin
        rem--;
        if (rem == 0) begin
          pass_done = 3'(1 << idx);
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_game_tick"}, 32'(game_tick), 0);
    chk({tag, "_pass_start"}, 32'(pass_start), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_vga_xyc"}, 32'({vga_x, vga_y, vga_colour}), 0);
    chk({tag, "_vga_plot"}, 32'(vga_plot), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_count"}, 32'(frame_count), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  function automatic bit sig_now(input int which);
    case (which)
      0:       return game_tick;
      1:       return frame_done;
      2:       return pass_start == 3'b100;
      default: return pass_start == 3'b001;
    endcase
  endfunction

  // Returns the number of cycles until the event, or -1 if the budget runs out.
  task automatic wait_sig(input int which, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sig_now(which)) begin
        n = i;
        break;
      end
    end
  endtask

  // Drive pass 0 with the given pixel, random data on the other passes; queue expected mux output.
  task automatic drive_req(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] c0,
                           input logic [2:0] plot);
    req_x      = {8'($urandom), 8'($urandom), x0};
    req_y      = {7'($urandom), 7'($urandom), y0};
    req_colour = {3'($urandom), 3'($urandom), c0};
    req_plot   = plot;
    exp_q.push_back({x0, y0, c0, plot[0]});
  endtask

  task automatic chk_mux(input string tag);
    logic [18:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(e));
    end
  endtask

  initial begin
    int n;
    int base;
    int fdb;
    int rd;
    int ex;
    rd = 0;
    reset = 1'b1; run = 1'b0;
    req_x = '0; req_y = '0; req_colour = '0; req_plot = '0;
    dly[0] = 5; dly[1] = 5; dly[2] = 5;
    step(3);
    reset = 1'b0;
    step();
    chk_zero("reset");
    fdb = fd_cnt;
    base = tick_cnt;
    step(30);
    chk("idle_no_tick", 32'(tick_cnt - base), 0);

    // Frame 1: every pass answers 5 cycles after its start.
    run = 1'b1;
    exp_starts.push_back(0); exp_starts.push_back(1); exp_starts.push_back(2);
    wait_sig(0, 40, n);
    chk("first_tick_cycle", 32'(n), 21);
    step();
    chk("start_p0", 32'(pass_start), 3'b001);
    chk("grant_p0", 32'(grant), 3'b001);
    chk("plot_before_req", 32'(vga_plot), 0);
    drive_req(8'h10, 7'h20, 3'b001, 3'b100);
    step();
    chk_mux("mux_foreign_plot");
    drive_req(8'd5, 7'd9, 3'b110, 3'b001);
    step();
    chk_mux("mux_p0_pixel");
    for (int i = 0; i < 3; i++) begin
      drive_req(8'($urandom), 7'($urandom), 3'($urandom), 3'($urandom));
      step();
      chk_mux($sformatf("mux_rand%0d", i));
    end
    req_x = {8'h42, 16'h0}; req_y = {7'h11, 14'h0}; req_colour = {3'h5, 6'h0}; req_plot = '0;
    wait_sig(1, 40, n);
    chk("frame1_len", 32'(n), 13);
    chk("frame_count1", 32'(frame_count), 1);
    chk("no_overrun", 32'(overrun), 0);
    chk("no_timeout", 32'(timeout_err), 0);
    while (exp_starts.size() != 0) begin
      ex = exp_starts.pop_front();
      chk($sformatf("start_order%0d", rd), 32'((rd < starts_obs.size()) ? starts_obs[rd] : -1),
          32'(ex));
      rd++;
    end

    // No owner between frames: plot strobes are blocked and x/y/colour hold.
    dly[1] = 0;
    req_x = {3{8'hAA}}; req_y = {3{7'h55}}; req_colour = 9'h1FF; req_plot = 3'b111;
    step();
    chk("hold_plot", 32'(vga_plot), 0);
    chk("hold_xyc", 32'({vga_x, vga_y, vga_colour}), 32'({8'h42, 7'h11, 3'h5}));
    chk("tick_period", 32'(game_tick), 1);
    chk("frame_done_once", 32'(fd_cnt - fdb), 1);
    req_x = '0; req_y = '0; req_colour = '0; req_plot = '0;

    // Frame 2: pass 1 never answers, so the watchdog ends it.
    base = g1_cnt;
    wait_sig(2, 60, n);
    chk("p2_start_after_wd", 32'(n), 23);
    chk("p1_grant_cycles", 32'(g1_cnt - base), 16);
    chk("timeout_err_set", 32'(timeout_err), 1);

    // Frames run longer than the tick period: tick is owed and taken straight after WAIT_TICK.
    dly[0] = 9; dly[1] = 9; dly[2] = 9;
    wait_sig(1, 40, n);
    chk("overrun_set", 32'(overrun), 1);
    base = tick_cnt;
    step();
    chk("pending_tick", 32'(game_tick), 1);
    wait_sig(1, 60, n);
    chk("frame3_len", 32'(n), 31);
    chk("single_tick_per_frame", 32'(tick_cnt - base), 1);
    step();
    chk("pending_tick2", 32'(game_tick), 1);
    step();
    chk("frame4_start", 32'(pass_start), 3'b001);
    run = 1'b0;
    wait_sig(1, 60, n);
    chk("frame4_completes", 32'(n), 30);
    base = tick_cnt;
    step(40);
    chk("no_tick_after_stop", 32'(tick_cnt - base), 0);
    chk("idle_grant", 32'(grant), 0);
    chk("frame_count4", 32'(frame_count), 4);

    // Restart keeps the owed tick, then reset lands mid-pass.
    run = 1'b1;
    wait_sig(3, 20, n);
    chk("pending_kept_restart", 32'(n), 3);
    req_x = {16'h0, 8'h33}; req_plot = 3'b001;
    step(2);
    chk("plot_before_reset", 32'(vga_plot), 1);
    reset = 1'b1;
    step();
    chk_zero("midreset");
    step();
    reset = 1'b0; run = 1'b0; req_x = '0; req_plot = '0;
    step(2);
    run = 1'b1;
    wait_sig(0, 40, n);
    chk("tick_after_reset", 32'(n), 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
